// File: rtl/qspi_flash_responder_pkg.sv
// qspi_pkg: opcodes, FSM encoding and helpers shared by the QSPI flash responder
package qspi_pkg;
   localparam logic [7:0] CMD_READ      = 8'h03;
   localparam logic [7:0] CMD_FAST_READ = 8'h0B;
   localparam logic [7:0] CMD_QUAD_OUT  = 8'h6B;
   localparam logic [7:0] CMD_JEDEC_ID  = 8'h9F;
   localparam int ADDR_FRAME_BITS = 24;
   typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_IGNORE} state_t;
   function automatic logic [7:0] jedec_byte(input logic [23:0] id, input logic [1:0] idx);
      return (idx == 2'd0) ? id[23:16] : (idx == 2'd1) ? id[15:8] : (idx == 2'd2) ? id[7:0] : 8'h00;
   endfunction
endpackage

// File: rtl/qspi_flash_responder_edge_sync.sv
// qspi_edge_sync: optional synchronizer chain plus history flop, emitting level and edges
module qspi_edge_sync #(
   parameter int W      = 1,
   parameter int STAGES = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] lvl_o,
   output logic [W-1:0] rise_o,
   output logic [W-1:0] fall_o
);
   logic [W-1:0] prev_q;
   generate
      if (STAGES == 0) begin : g_direct
         assign lvl_o = d_i;
      end else begin : g_sync
         logic [W-1:0] sync_q [STAGES];
         // carry the raw pads through the metastability chain
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
            end else begin
               sync_q[0] <= d_i;
               for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
         end
         assign lvl_o = sync_q[STAGES-1];
      end
   endgenerate
   // previous synced level, compared against the current one for edges
   always_ff @(posedge clk) prev_q <= reset ? '0 : lvl_o;
   assign rise_o = lvl_o & ~prev_q;
   assign fall_o = ~lvl_o & prev_q;
endmodule

// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder: SPI/QSPI flash target streaming bytes from a byte-wide memory port
module qspi_flash_responder
   import qspi_pkg::*;
#(
   parameter int          ADDR_BITS    = 24,
   parameter int          DUMMY_CLOCKS = 8,
   parameter int          SYNC_STAGES  = 0,
   parameter logic [23:0] JEDEC_ID     = 24'hEF4018
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 spi_clk,
   input  logic                 cs_n,
   input  logic [3:0]           dq_in,
   output logic [3:0]           dq_out,
   output logic [3:0]           dq_oe,
   output logic                 mem_req,
   output logic [ADDR_BITS-1:0] mem_addr,
   input  logic                 mem_ack,
   input  logic [7:0]           mem_data,
   output logic                 busy,
   output logic                 underrun
);
   logic [1:0] ctl_lvl, ctl_rise, ctl_fall;
   logic [3:0] dq_lvl, dq_rise, dq_fall;
   qspi_edge_sync #(.W(2), .STAGES(SYNC_STAGES)) u_ctl (
      .clk(clk), .reset(reset), .d_i({cs_n, spi_clk}), .lvl_o(ctl_lvl), .rise_o(ctl_rise), .fall_o(ctl_fall)
   );
   qspi_edge_sync #(.W(4), .STAGES(SYNC_STAGES)) u_dq (
      .clk(clk), .reset(reset), .d_i(dq_in), .lvl_o(dq_lvl), .rise_o(dq_rise), .fall_o(dq_fall)
   );
   logic unused_ok;
   assign unused_ok = ^{ctl_lvl[0], ctl_rise[1], dq_lvl[3:1], dq_rise, dq_fall};
   logic cs_hi, cs_fall, sclk_rise, sclk_fall;
   assign cs_hi     = ctl_lvl[1];
   assign cs_fall   = ctl_fall[1];
   assign sclk_rise = ctl_rise[0];
   assign sclk_fall = ctl_fall[0];
   state_t               state_q;
   logic [7:0]           cnt_q, out_q, pre_q;
   logic [22:0]          sh_q;
   logic [1:0]           jidx_q;
   logic [3:0]           dq_out_q, dq_oe_q;
   logic [ADDR_BITS-1:0] mem_addr_q;
   logic                 quad_q, jedec_q, dummy_q, pre_vld_q, mem_req_q, underrun_q;
   logic [23:0] sh_next;
   logic [7:0]  op, load, cur;
   logic        have_byte, last_fall, is_rd;
   logic [3:0]  oe_data;
   assign sh_next   = {sh_q, dq_lvl[0]};
   assign op        = sh_next[7:0];
   assign is_rd     = (op == CMD_READ) | (op == CMD_FAST_READ) | (op == CMD_QUAD_OUT);
   assign have_byte = pre_vld_q | (mem_req_q & mem_ack);
   assign load      = jedec_q ? jedec_byte(JEDEC_ID, jidx_q) : !have_byte ? 8'h00 : pre_vld_q ? pre_q : mem_data;
   assign cur       = (cnt_q == 8'd0) ? load : out_q;
   assign last_fall = quad_q ? (cnt_q == 8'd1) : (cnt_q == 8'd7);
   assign oe_data   = quad_q ? 4'b1111 : 4'b0010;
   // protocol FSM: command/address/dummy decode, byte streaming and prefetch
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE; cnt_q <= '0; out_q <= '0; pre_q <= '0; sh_q <= '0; jidx_q <= '0;
         dq_out_q <= '0; dq_oe_q <= '0; mem_addr_q <= '0; quad_q <= 1'b0; jedec_q <= 1'b0;
         dummy_q <= 1'b0; pre_vld_q <= 1'b0; mem_req_q <= 1'b0; underrun_q <= 1'b0;
      end else if (cs_hi) begin
         state_q <= ST_IDLE; cnt_q <= '0; dq_out_q <= '0; dq_oe_q <= '0;
         mem_req_q <= 1'b0; pre_vld_q <= 1'b0;
      end else begin
         if (mem_req_q && mem_ack) begin
            pre_q <= mem_data; pre_vld_q <= 1'b1; mem_req_q <= 1'b0;
         end
         case (state_q)
            ST_IDLE: if (cs_fall) begin
               state_q <= ST_CMD; cnt_q <= '0; underrun_q <= 1'b0; jidx_q <= '0;
               quad_q <= 1'b0; jedec_q <= 1'b0; pre_vld_q <= 1'b0;
            end
            ST_CMD: if (sclk_rise) begin
               sh_q <= sh_next[22:0];
               cnt_q <= (cnt_q == 8'd7) ? 8'd0 : cnt_q + 8'd1;
               if (cnt_q == 8'd7) begin
                  quad_q <= op == CMD_QUAD_OUT;
                  jedec_q <= op == CMD_JEDEC_ID;
                  dummy_q <= (op != CMD_READ) && (DUMMY_CLOCKS != 0);
                  state_q <= is_rd ? ST_ADDR : (op == CMD_JEDEC_ID) ? ST_DATA : ST_IGNORE;
                  dq_oe_q <= (op == CMD_JEDEC_ID) ? 4'b0010 : 4'b0000;
               end
            end
            ST_ADDR: if (sclk_rise) begin
               sh_q <= sh_next[22:0];
               cnt_q <= cnt_q + 8'd1;
               if (cnt_q == 8'(ADDR_FRAME_BITS - 1)) begin
                  cnt_q <= '0; mem_req_q <= 1'b1; mem_addr_q <= sh_next[ADDR_BITS-1:0];
                  state_q <= dummy_q ? ST_DUMMY : ST_DATA;
                  dq_oe_q <= dummy_q ? 4'b0000 : oe_data;
               end
            end
            ST_DUMMY: if (sclk_rise) begin
               cnt_q <= cnt_q + 8'd1;
               if (cnt_q == 8'(DUMMY_CLOCKS - 1)) begin
                  cnt_q <= '0; state_q <= ST_DATA; dq_oe_q <= oe_data;
               end
            end
            ST_DATA: if (sclk_fall) begin
               dq_out_q <= quad_q ? cur[7:4] : {2'b00, cur[7], 1'b0};
               out_q <= quad_q ? {cur[3:0], 4'h0} : {cur[6:0], 1'b0};
               cnt_q <= last_fall ? 8'd0 : cnt_q + 8'd1;
               if (cnt_q == 8'd0) begin
                  if (jedec_q) jidx_q <= (jidx_q == 2'd3) ? 2'd3 : jidx_q + 2'd1;
                  else if (have_byte) begin
                     mem_addr_q <= mem_addr_q + 1'b1; mem_req_q <= 1'b1; pre_vld_q <= 1'b0;
                  end else underrun_q <= 1'b1;
               end
            end
            ST_IGNORE: state_q <= ST_IGNORE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end
   assign dq_out   = dq_out_q;
   assign dq_oe    = dq_oe_q;
   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign busy     = state_q != ST_IDLE;
   assign underrun = underrun_q;
endmodule

// File: tb/tb_qspi_flash_responder.sv
// tb_qspi_flash_responder: randomized SPI master, memory model and byte scoreboard
module tb_qspi_flash_responder;
   localparam int H = 4;
   logic        clk = 1'b0, reset = 1'b1, spi_clk = 1'b0, cs_n = 1'b1;
   logic [3:0]  dq_in = '0, dq_out, dq_oe;
   logic        mem_req, mem_ack, busy, underrun;
   logic [23:0] mem_addr;
   logic [7:0]  mem_data;
   int vectors = 0, errors = 0;
   int lat = 0, wcnt = 0;
   logic [7:0]  salt = '0;
   bit          starve = 0, mem_req_seen = 0;
   logic [23:0] last_addr;
   logic [7:0]  exp_q[$];
   logic [23:0] exp_addr[$];
   logic [7:0]  jid [3] = '{8'hEF, 8'h40, 8'h18};
   logic [7:0]  mon_sh = '0;
   int          mon_nb = 0;

   qspi_flash_responder dut (
      .clk(clk), .reset(reset), .spi_clk(spi_clk), .cs_n(cs_n), .dq_in(dq_in),
      .dq_out(dq_out), .dq_oe(dq_oe), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_data(mem_data), .busy(busy), .underrun(underrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // memory: acknowledges a held request after lat cycles with byte addr[7:0]+salt
   initial begin
      mem_ack = 1'b0;
      mem_data = '0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (mem_req) begin
            mem_req_seen = 1;
            if (wcnt >= lat) begin
               mem_ack = 1'b1;
               mem_data = mem_addr[7:0] + salt;
               wcnt = 0;
               if (exp_addr.size() > 0) chk("fetch_addr", mem_addr, exp_addr.pop_front());
            end else wcnt++;
         end else wcnt = 0;
      end
   end

   // monitor: the master samples on spi_clk rise; assemble bytes and score them
   always @(posedge spi_clk or posedge cs_n) begin
      if (cs_n) mon_nb = 0;
      else if (dq_oe != 4'b0000) begin
         if (dq_oe == 4'b1111) begin
            mon_sh = {mon_sh[3:0], dq_out};
            mon_nb += 4;
         end else begin
            mon_sh = {mon_sh[6:0], dq_out[1]};
            mon_nb += 1;
         end
         if (mon_nb >= 8) begin
            mon_nb = 0;
            if (exp_q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL data_byte: got %h with nothing expected", mon_sh);
            end else chk("data_byte", mon_sh, exp_q.pop_front());
         end
      end
   end

   task automatic tick(input logic [3:0] d);
      spi_clk = 1'b0;
      dq_in = d;
      repeat (H) @(negedge clk);
      spi_clk = 1'b1;
      repeat (H) @(negedge clk);
   endtask

   task automatic hdr(input logic [7:0] op, input logic [23:0] addr, input int nab);
      cs_n = 1'b0;
      repeat (H) @(negedge clk);
      for (int b = 7; b >= 0; b--) tick({3'b000, op[b]});
      for (int b = 0; b < nab; b++) tick({3'b000, addr[23-b]});
   endtask

   task automatic xfer(input logic [7:0] op, input logic [23:0] addr, input int nbytes);
      bit rd, quad, jd;
      int nd;
      logic [23:0] a;
      rd = (op == 8'h03) || (op == 8'h0B) || (op == 8'h6B);
      quad = op == 8'h6B;
      jd = op == 8'h9F;
      nd = (op == 8'h0B || op == 8'h6B) ? 8 : 0;
      for (int i = 0; i < nbytes; i++) begin
         a = addr + 24'(i);
         if (jd) exp_q.push_back(i < 3 ? jid[i] : 8'h00);
         else if (rd && starve) exp_q.push_back(8'h00);
         else if (rd) begin
            exp_q.push_back(a[7:0] + salt);
            exp_addr.push_back(a);
         end
      end
      mem_req_seen = 0;
      hdr(op, addr, rd ? 24 : 0);
      if (nd > 0) begin
         chk("oe_before_dummy", dq_oe, 4'b0000);
         for (int i = 0; i < nd; i++) tick(4'b0000);
      end
      for (int i = 0; i < nbytes * (quad ? 2 : 8); i++) tick(4'b0000);
      chk("busy_active", busy, 1'b1);
      chk("oe_data", dq_oe, quad ? 4'b1111 : (rd || jd) ? 4'b0010 : 4'b0000);
      last_addr = mem_addr;
      cs_n = 1'b1;
      spi_clk = 1'b0;
      repeat (2) @(negedge clk);
      chk("oe_after_cs", dq_oe, 4'b0000);
      chk("busy_after_cs", busy, 1'b0);
      chk("req_after_cs", mem_req, 1'b0);
      chk("bytes_pending", exp_q.size(), 0);
      chk("fetches_pending", exp_addr.size(), 0);
      if (jd) chk("jedec_no_req", mem_req_seen, 1'b0);
      repeat (H) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_oe", dq_oe, 4'b0000);
      chk("rst_out", dq_out, 4'b0000);
      chk("rst_req", mem_req, 1'b0);
      chk("rst_addr", mem_addr, 24'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_underrun", underrun, 1'b0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      lat = 1;
      xfer(8'h03, 24'h000010, 4);
      chk("read_end_addr", last_addr, 24'h000014);
      xfer(8'h6B, 24'h0000FE, 3);
      xfer(8'h9F, 24'h0, 4);
      xfer(8'h03, 24'hFFFFFF, 2);

      starve = 1;
      lat = 40;
      xfer(8'h03, 24'h001234, 1);
      chk("underrun_set", underrun, 1'b1);
      repeat (5) @(negedge clk);
      chk("underrun_sticky", underrun, 1'b1);
      starve = 0;
      lat = 0;
      cs_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("underrun_clear", underrun, 1'b0);
      cs_n = 1'b1;
      repeat (H) @(negedge clk);

      hdr(8'h03, 24'hABCDEF, 5);
      chk("abort_busy_before", busy, 1'b1);
      cs_n = 1'b1;
      spi_clk = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 1'b0);
      chk("abort_oe", dq_oe, 4'b0000);
      chk("abort_req", mem_req, 1'b0);
      repeat (H) @(negedge clk);

      exp_q.push_back(8'h20);
      exp_addr.push_back(24'h000020);
      hdr(8'h03, 24'h000020, 24);
      for (int i = 0; i < 11; i++) tick(4'b0000);
      chk("pre_reset_oe", dq_oe, 4'b0010);
      reset = 1'b1;
      @(negedge clk);
      chk("reset_oe", dq_oe, 4'b0000);
      chk("reset_req", mem_req, 1'b0);
      chk("reset_busy", busy, 1'b0);
      reset = 1'b0;
      cs_n = 1'b1;
      spi_clk = 1'b0;
      repeat (H) @(negedge clk);
      chk("reset_bytes_pending", exp_q.size(), 0);
      exp_addr.delete();

      for (int n = 0; n < 10; n++) begin
         logic [7:0] ops [5] = '{8'h03, 8'h0B, 8'h6B, 8'h9F, 8'h05};
         salt = 8'($urandom);
         lat = $urandom_range(0, 3);
         xfer(ops[$urandom_range(0, 4)], 24'($urandom), $urandom_range(1, 5));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
